// File: rtl/imem_dmem_arbiter.sv
// Arbitrates a single-port SRAM between instruction fetch (read only) and the
// core's data port. Data wins by default; a bounded streak keeps fetch alive.

module imem_dmem_rdata_hold #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rvalid,
  input  logic [DWIDTH-1:0] dout,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      hold_q <= '0;
    else if (rvalid) hold_q <= dout;
  end

  assign rdata = rvalid ? dout : hold_q;
endmodule

module imem_dmem_arbiter #(
  parameter int          AWIDTH     = 12,
  parameter int          DWIDTH     = 32,
  parameter int          BEWIDTH    = 4,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req,
  input  logic [AWIDTH-1:0]  if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [DWIDTH-1:0]  if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [BEWIDTH-1:0] d_be,
  input  logic [AWIDTH-1:0]  d_addr,
  input  logic [DWIDTH-1:0]  d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [DWIDTH-1:0]  d_rdata,
  output logic               sram_csn,
  output logic               sram_wen,
  output logic [AWIDTH-1:0]  sram_addr,
  output logic [BEWIDTH-1:0] sram_be,
  output logic [DWIDTH-1:0]  sram_di,
  input  logic [DWIDTH-1:0]  sram_dout,
  output logic [15:0]        contention_cnt
);
  localparam int SW = $clog2(STREAK_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  logic [SW-1:0] streak_q;
  logic          streak_full;
  owner_e        owner_q, owner_d;
  logic [15:0]   cnt_q;

  // Grants are gated by rst_n so nothing reaches the SRAM while in reset.
  assign streak_full = (streak_q == SW'(STREAK_MAX));
  assign d_gnt  = rst_n & d_req  & ~(if_req & streak_full);
  assign if_gnt = rst_n & if_req & (~d_req | streak_full);

  always_comb begin
    sram_csn  = 1'b1;
    sram_wen  = 1'b1;
    sram_addr = '0;
    sram_be   = '0;
    sram_di   = '0;
    if (d_gnt) begin
      sram_csn  = 1'b0;
      sram_wen  = ~d_we;
      sram_addr = d_addr;
      sram_be   = d_be;
      sram_di   = d_wdata;
    end else if (if_gnt) begin
      sram_csn  = 1'b0;
      sram_addr = if_addr;
      sram_be   = '1;
    end
  end

  // Streak counts data wins while fetch is waiting; any fetch win or idle fetch clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     streak_q <= '0;
    else if (!if_req || if_gnt)     streak_q <= '0;
    else if (d_gnt && !streak_full) streak_q <= streak_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt_q <= '0;
    else if (if_req && d_req && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign contention_cnt = cnt_q;

  // Response owner: one-deep pipeline matching the SRAM's single-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt)              owner_d = OWN_IF;
    else if (d_gnt && !d_we) owner_d = OWN_D;
  end

  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (owner_q)
      OWN_IF:  if_rvalid = 1'b1;
      OWN_D:   d_rvalid  = 1'b1;
      default: ;
    endcase
  end

  logic [1:0]             rvalid_v;
  logic [1:0][DWIDTH-1:0] rdata_v;
  assign rvalid_v = {d_rvalid, if_rvalid};

  for (genvar p = 0; p < 2; p++) begin : g_port
    imem_dmem_rdata_hold #(.DWIDTH(DWIDTH)) u_hold (
      .clk    (clk),
      .rst_n  (rst_n),
      .rvalid (rvalid_v[p]),
      .dout   (sram_dout),
      .rdata  (rdata_v[p])
    );
  end

  assign if_rdata = rdata_v[0];
  assign d_rdata  = rdata_v[1];
endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Arbitrates one single-port SRAM (`SP_SRAM`-style, synchronous, active-low chip select, `WEN` 0 = write) between two requesters:
- the instruction-fetch port (read only);
- the data-memory port of the 5-stage core (loads and stores).

Data accesses win by default. A bounded-streak rule guarantees that fetch is never starved. The arbiter produces grant/valid handshakes and a saturating contention counter.

## Interface
Parameters:
- `AWIDTH`, 12: SRAM word-address width.
- `DWIDTH`, 32: data width.
- `BEWIDTH`, 4: byte-enable width.
- `STREAK_MAX`, 4: maximum consecutive data grants while fetch waits. Legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request, held until granted.
- `if_addr` in AWIDTH: fetch address.
- `if_gnt` out 1: fetch accepted this cycle (combinational).
- `if_rvalid` out 1: fetch read data valid.
- `if_rdata` out DWIDTH: fetch read data.
- `d_req` in 1: data request, held until granted.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in BEWIDTH: byte enables.
- `d_addr` in AWIDTH: data address.
- `d_wdata` in DWIDTH: store data.
- `d_gnt` out 1: data accepted this cycle (combinational).
- `d_rvalid` out 1: load data valid.
- `d_rdata` out DWIDTH: load data.
- `sram_csn` out 1: chip select, 0 = access.
- `sram_wen` out 1: 0 = write, 1 = read.
- `sram_addr` out AWIDTH: SRAM address.
- `sram_be` out BEWIDTH: SRAM byte enables.
- `sram_di` out DWIDTH: SRAM write data.
- `sram_dout` in DWIDTH: SRAM read data, valid the cycle after a read access.
- `contention_cnt` out 16: count of cycles with both requests asserted. Saturates at 16'hFFFF.

## Operation
- **Grant decision (combinational):**
  - `d_req` only: grant data.
  - `if_req` only: grant fetch.
  - Both asserted: grant data unless `streak == STREAK_MAX`, in which case grant fetch.
  - At most one grant per cycle. `if_gnt & d_gnt` is never 1.
- **SRAM drive:**
  - On a grant: `sram_csn = 0`, and addr/be/di come from the winner.
  - Fetch access: `sram_wen = 1`, `sram_be` all ones.
  - Data access: `sram_wen = ~d_we`.
  - No grant: `sram_csn = 1`, `sram_wen = 1`, and addr/be/di are 0.
- **Streak counter** (width $clog2(STREAK_MAX+1)), updated on each clock edge:
  - Cleared when fetch is granted or `if_req = 0`.
  - Incremented when data is granted while `if_req = 1`.
  - Never exceeds STREAK_MAX.
- **Response tracking:** a 2-bit owner register, states NONE / IF_RD / D_RD.
  - Loaded each cycle with IF_RD (fetch granted), D_RD (data load granted), or NONE (store granted or no grant).
  - `if_rvalid = (owner == IF_RD)`; `d_rvalid = (owner == D_RD)`.
- **Read data:**
  - `x_rdata` = `sram_dout` while `x_rvalid` is 1.
  - Otherwise `x_rdata` holds the last value delivered on that port, kept in a per-port hold register loaded on rvalid cycles.
- **Stores:** complete at the grant cycle. No rvalid is generated.
- **contention_cnt:** increments on every cycle with `if_req & d_req`, regardless of grant. Saturates.
- **Requester protocol:** a requester must keep req and its fields stable until gnt. Dropping req before gnt is legal and cancels the request with no side effects.
- **While `rst_n = 0`:** `if_gnt`, `d_gnt` are forced 0, `sram_csn` is forced 1, and the other SRAM outputs are forced to their idle values.

## Timing
- **Reset values:**
  - owner = NONE, so `if_rvalid = d_rvalid = 0`.
  - rdata hold registers = 0, so `if_rdata = d_rdata = 0`.
  - streak = 0.
  - `contention_cnt = 0`.
  - `sram_csn = 1`, `sram_wen = 1`, addr/be/di = 0.
- **Latency:**
  - Grant is in the same cycle as req when uncontended.
  - Read data arrives exactly 1 cycle after the grant.
  - Throughput is 1 access per cycle, with back-to-back grants to the same or alternating ports.
- **Reset mid-operation:** asserting `rst_n` in the cycle after a read grant clears owner asynchronously. That read's rvalid is lost and never reasserted.
- **Simultaneous requests with `STREAK_MAX = 1`:** strict alternation D, I, D, I…
- **Pipelined reads:** a grant in cycle N+1 does not disturb the rvalid for the grant in cycle N. Owner is a single pipeline register, so there are no overlapping-response conflicts.
- **Counter wrap:** `contention_cnt` at 16'hFFFF with contention stays at 16'hFFFF.

## Test plan
- **Reset:** assert `rst_n = 0` with both reqs high, then release.
  - During reset: gnts 0, `sram_csn = 1`, all counters 0.
  - First post-reset cycle: `d_gnt = 1`.
- **Single fetch:** `if_req` addr 12'h010, with SRAM model returning 32'hDEADBEEF.
  - `if_gnt` in cycle 0.
  - `if_rvalid = 1` and `if_rdata = 32'hDEADBEEF` in cycle 1.
  - `if_rdata` holds the value in cycle 2.
- **Store then load, same address:** `d_we = 1`, be 4'b0011, data 32'h12345678 to addr 5, then a load from addr 5.
  - `sram_wen = 0` then 1.
  - `d_rvalid` one cycle after the load grant.
  - `d_rdata = 32'h00005678` (SRAM model with BE merge over zeroed memory).
- **Starvation guard:** `STREAK_MAX = 4`, both reqs held high for 10 cycles.
  - Grant pattern: D D D D I D D D D I.
  - `contention_cnt = 10`.
- **Cancel:** `if_req` pulsed for one cycle while `d_req` wins.
  - No fetch access is issued.
  - `if_rvalid` is never asserted.
  - streak resets to 0.
- **Async reset after a read grant:** `rst_n` low for half a cycle right after a fetch grant.
  - `if_rvalid` drops immediately.
  - No response appears after release.
